alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//   ALU reservation station: buffers dispatched ALU/branch micro-ops until both operands are
//   known, snoops CDB broadcasts for missing operands, and issues one ready op per cycle.
//   Sits between dispatch and the combinational ALU exec stage. Drives that stage's
//   rs_ok/opt/rs1/rs2/imm/en inputs directly from registers. Its CDB_1 result is fed back here.
// PARAMETERS
//   RS_SIZE   8   number of entries (power of 2, >=2)
//   TAG_W     4   ROB tag width; must match exec en width
// PORTS
//   clk_in     in   1      clock, rising edge
//   rst_in     in   1      asynchronous, active-low reset
//   rdy_in     in   1      global ready; low = stall, all state frozen
//   clear      in   1      flush (mispredict): drop every entry
//   disp_valid in   1      dispatch request this cycle
//   disp_opt   in   6      opcode (exec opt encoding)
//   disp_vj    in   32     operand j value (valid when disp_rj)
//   disp_rj    in   1      operand j ready
//   disp_qj    in   TAG_W  ROB tag producing j (used when !disp_rj)
//   disp_vk/disp_rk/disp_qk  in 32/1/TAG_W  same for operand k
//   disp_imm   in   32     immediate
//   disp_rob   in   TAG_W  destination ROB tag
//   rs_full    out  1      all entries busy (combinational from registered busy bits)
//   CDB_1_ok/CDB_1_en/CDB_1_val  in 1/TAG_W/32  ALU result broadcast
//   CDB_2_ok/CDB_2_en/CDB_2_val  in 1/TAG_W/32  load/store result broadcast
//   rs_ok      out  1      issued op valid (registered)
//   opt,rs1,rs2,imm,en  out 6/32/32/32/TAG_W  issued op fields (registered)
// BEHAVIOUR
//   Entry state: busy, opt, vj, rj, qj, vk, rk, qk, imm, rob.
//   Reset (rst_in=0, async): all busy=0; rs_ok=0; opt/rs1/rs2/imm/en=0.
//   rdy_in=0: no state change except rs_ok<=0 at the edge (no duplicate broadcast).
//   clear=1 (rdy_in=1): next edge all busy=0, rs_ok=0; dispatch/CDB ignored that cycle.
//   Dispatch: if disp_valid && !rs_full, write lowest-index non-busy entry (pre-edge busy).
//     Dispatch while rs_full is dropped silently. Dispatch must honour rs_full.
//     Same-cycle forwarding: if !disp_rj and a CDB has ok && en==disp_qj, store that val, rj=1.
//     CDB_1 has priority if both match (cannot legally both match). Same for k.
//   Wakeup: every busy entry with rj=0 (or rk=0) and a matching CDB tag captures val, sets ready.
//   Issue select: lowest-index entry with busy && rj && rk in pre-edge state.
//     Ops woken this cycle are eligible next cycle. The selected entry is freed at the edge.
//     rs_ok<=1; opt/rs1(vj)/rs2(vk)/imm/en(rob) loaded from it.
//     No candidate: rs_ok<=0 and the data outputs hold their previous values.
//   Latency: op dispatched ready at edge N -> rs_ok high after edge N+1 (one cycle).
//     Op woken by CDB at edge N -> issued at edge N+1.
//   Simultaneous issue+dispatch: a slot freed by issue is not reusable in the same cycle.
//     rs_full stays as computed from pre-edge busy.
//   At most one issue per cycle; rs_ok pulses one cycle per op. Ordering is by index, not age.
//   Reset mid-operation dominates everything; clear dominates dispatch, wakeup and issue.
// TESTING
//   Reset, then dispatch ADD vj=5 vk=7 rob=3, both ready -> next cycle rs_ok=1 opt=ADD rs1=5 rs2=7 en=3.
//   Dispatch ADDI rj=0 qj=2 imm=4; 2 cycles later CDB_2 ok en=2 val=10 -> issue next cycle rs1=10 imm=4 en=rob.
//   Dispatch with qj=6 while CDB_1 ok en=6 val=0x55 same cycle -> entry captures 0x55, issues next cycle.
//   Fill 8 entries with unready ops -> rs_full=1; 9th dispatch dropped; one wakeup+issue -> rs_full=0.
//   Three ready ops in entries 0,1,2 -> issued in index order on consecutive cycles; rs_ok 3 cycles high.
//   Hold rdy_in=0 two cycles with ready entry -> rs_ok=0, nothing issued; assert clear -> all freed, no issue.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, snoops both CDBs, issues the lowest ready entry.
// Latency: an op ready at edge N issues at edge N+1; rdy_in=0 freezes all state, rs_full gates dispatch.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [5:0]       disp_opt,
  input  logic [31:0]      disp_vj,
  input  logic             disp_rj,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_rk,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [31:0]      disp_imm,
  input  logic [TAG_W-1:0] disp_rob,
  output logic             rs_full,
  input  logic             CDB_1_ok,
  input  logic [TAG_W-1:0] CDB_1_en,
  input  logic [31:0]      CDB_1_val,
  input  logic             CDB_2_ok,
  input  logic [TAG_W-1:0] CDB_2_en,
  input  logic [31:0]      CDB_2_val,
  output logic             rs_ok,
  output logic [5:0]       opt,
  output logic [31:0]      rs1,
  output logic [31:0]      rs2,
  output logic [31:0]      imm,
  output logic [TAG_W-1:0] en
);

  typedef struct packed {
    logic             busy;
    logic [5:0]       opt;
    logic [31:0]      vj;
    logic             rj;
    logic [TAG_W-1:0] qj;
    logic [31:0]      vk;
    logic             rk;
    logic [TAG_W-1:0] qk;
    logic [31:0]      imm;
    logic [TAG_W-1:0] rob;
  } ent_t;

  localparam logic [RS_SIZE-1:0] ONE = RS_SIZE'(1);

  ent_t               ents [RS_SIZE];
  ent_t               sel_ent;
  ent_t               new_ent;
  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] rdy_vec;
  logic [RS_SIZE-1:0] free_oh;
  logic [RS_SIZE-1:0] issue_oh;
  logic               issue_vld;
  logic               disp_ok;

  always_comb begin
    busy_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i] = ents[i].busy;
      rdy_vec[i]  = ents[i].busy && ents[i].rj && ents[i].rk;
    end
  end

  // Lowest set / lowest clear bit isolation; both work on pre-edge busy state.
  assign free_oh   = ~busy_vec & (busy_vec + ONE);
  assign issue_oh  = rdy_vec & (~rdy_vec + ONE);
  assign rs_full   = &busy_vec;
  assign issue_vld = |rdy_vec;
  assign disp_ok   = disp_valid && !rs_full;

  always_comb begin
    sel_ent = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (rdy_vec[i]) sel_ent = ents[i];
    end
  end

  always_comb begin
    new_ent      = '0;
    new_ent.busy = 1'b1;
    new_ent.opt  = disp_opt;
    new_ent.vj   = disp_vj;
    new_ent.rj   = disp_rj;
    new_ent.qj   = disp_qj;
    new_ent.vk   = disp_vk;
    new_ent.rk   = disp_rk;
    new_ent.qk   = disp_qk;
    new_ent.imm  = disp_imm;
    new_ent.rob  = disp_rob;
    // Operand produced on a CDB in the dispatch cycle would otherwise be missed forever.
    if (!disp_rj) begin
      if (CDB_1_ok && CDB_1_en == disp_qj) begin
        new_ent.vj = CDB_1_val;
        new_ent.rj = 1'b1;
      end else if (CDB_2_ok && CDB_2_en == disp_qj) begin
        new_ent.vj = CDB_2_val;
        new_ent.rj = 1'b1;
      end
    end
    if (!disp_rk) begin
      if (CDB_1_ok && CDB_1_en == disp_qk) begin
        new_ent.vk = CDB_1_val;
        new_ent.rk = 1'b1;
      end else if (CDB_2_ok && CDB_2_en == disp_qk) begin
        new_ent.vk = CDB_2_val;
        new_ent.rk = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ents[i] <= '0;
      rs_ok <= 1'b0;
      opt   <= '0;
      rs1   <= '0;
      rs2   <= '0;
      imm   <= '0;
      en    <= '0;
    end else if (!rdy_in) begin
      rs_ok <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) ents[i].busy <= 1'b0;
      rs_ok <= 1'b0;
    end else begin
      // Wakeup, issue and dispatch touch disjoint entries, so their order here is free.
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ents[i].busy && !ents[i].rj) begin
          if (CDB_1_ok && CDB_1_en == ents[i].qj) begin
            ents[i].vj <= CDB_1_val;
            ents[i].rj <= 1'b1;
          end else if (CDB_2_ok && CDB_2_en == ents[i].qj) begin
            ents[i].vj <= CDB_2_val;
            ents[i].rj <= 1'b1;
          end
        end
        if (ents[i].busy && !ents[i].rk) begin
          if (CDB_1_ok && CDB_1_en == ents[i].qk) begin
            ents[i].vk <= CDB_1_val;
            ents[i].rk <= 1'b1;
          end else if (CDB_2_ok && CDB_2_en == ents[i].qk) begin
            ents[i].vk <= CDB_2_val;
            ents[i].rk <= 1'b1;
          end
        end
        if (issue_oh[i]) ents[i].busy <= 1'b0;
        if (disp_ok && free_oh[i]) ents[i] <= new_ent;
      end
      rs_ok <= issue_vld;
      if (issue_vld) begin
        opt <= sel_ent.opt;
        rs1 <= sel_ent.vj;
        rs2 <= sel_ent.vk;
        imm <= sel_ent.imm;
        en  <= sel_ent.rob;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: table vectors, directed corner sequences and a random run against a queue-free array model.
module tb_alu_rs;
  localparam int N = 8;
  localparam logic [5:0] ADD  = 6'd1;
  localparam logic [5:0] ADDI = 6'd2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, disp_valid;
  logic [5:0]  disp_opt;
  logic [31:0] disp_vj, disp_vk, disp_imm;
  logic        disp_rj, disp_rk;
  logic [3:0]  disp_qj, disp_qk, disp_rob;
  logic        rs_full;
  logic        CDB_1_ok, CDB_2_ok;
  logic [3:0]  CDB_1_en, CDB_2_en;
  logic [31:0] CDB_1_val, CDB_2_val;
  logic        rs_ok;
  logic [5:0]  opt;
  logic [31:0] rs1, rs2, imm;
  logic [3:0]  en;

  alu_rs #(.RS_SIZE(N), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .disp_valid(disp_valid), .disp_opt(disp_opt), .disp_vj(disp_vj), .disp_rj(disp_rj),
    .disp_qj(disp_qj), .disp_vk(disp_vk), .disp_rk(disp_rk), .disp_qk(disp_qk),
    .disp_imm(disp_imm), .disp_rob(disp_rob), .rs_full(rs_full),
    .CDB_1_ok(CDB_1_ok), .CDB_1_en(CDB_1_en), .CDB_1_val(CDB_1_val),
    .CDB_2_ok(CDB_2_ok), .CDB_2_en(CDB_2_en), .CDB_2_val(CDB_2_val),
    .rs_ok(rs_ok), .opt(opt), .rs1(rs1), .rs2(rs2), .imm(imm), .en(en)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit        busy;
    bit [5:0]  opt;
    bit [31:0] vj, vk, imm;
    bit        rj, rk;
    bit [3:0]  qj, qk, rob;
  } m_ent_t;

  m_ent_t    m [N];
  bit        m_ok;
  bit [5:0]  m_opt;
  bit [31:0] m_rs1, m_rs2, m_imm;
  bit [3:0]  m_en;
  int        n_tests = 0;
  int        n_fail  = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj;
    logic        rj;
    logic [3:0]  qj;
    logic [31:0] vk;
    logic        rk;
    logic [3:0]  qk;
    logic [3:0]  rob;
    logic        c1_ok;
    logic [3:0]  c1_en;
    logic [31:0] c1_val;
    logic        c2_ok;
    logic [3:0]  c2_en;
    logic [31:0] c2_val;
    logic        exp_ok;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m[i] = '{default: 0};
    m_ok = 0; m_opt = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_en = 0;
  endtask

  // Returns whether some CDB is broadcasting tag q; CDB_1 wins if both are.
  function automatic bit cdb_hit(input bit [3:0] q, output bit [31:0] v);
    v = 0;
    if (CDB_1_ok && CDB_1_en == q) begin v = CDB_1_val; return 1; end
    if (CDB_2_ok && CDB_2_en == q) begin v = CDB_2_val; return 1; end
    return 0;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 0;
    return 1;
  endfunction

  task automatic model_step();
    int iss;
    int fre;
    bit [31:0] v;
    iss = -1;
    fre = -1;
    if (!rdy_in) begin
      m_ok = 0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_ok = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (iss < 0 && m[i].busy && m[i].rj && m[i].rk) iss = i;
        if (fre < 0 && !m[i].busy) fre = i;
      end
      for (int i = 0; i < N; i++) begin
        if (m[i].busy && !m[i].rj && cdb_hit(m[i].qj, v)) begin m[i].vj = v; m[i].rj = 1; end
        if (m[i].busy && !m[i].rk && cdb_hit(m[i].qk, v)) begin m[i].vk = v; m[i].rk = 1; end
      end
      m_ok = (iss >= 0);
      if (iss >= 0) begin
        m_opt = m[iss].opt; m_rs1 = m[iss].vj; m_rs2 = m[iss].vk;
        m_imm = m[iss].imm; m_en = m[iss].rob;
        m[iss].busy = 0;
      end
      if (disp_valid && fre >= 0) begin
        m[fre] = '{busy: 1, opt: disp_opt, vj: disp_vj, vk: disp_vk, imm: disp_imm,
                   rj: disp_rj, rk: disp_rk, qj: disp_qj, qk: disp_qk, rob: disp_rob};
        if (!disp_rj && cdb_hit(disp_qj, v)) begin m[fre].vj = v; m[fre].rj = 1; end
        if (!disp_rk && cdb_hit(disp_qk, v)) begin m[fre].vk = v; m[fre].rk = 1; end
      end
    end
  endtask

  task automatic idle();
    rdy_in = 1; clear = 0; disp_valid = 0; CDB_1_ok = 0; CDB_2_ok = 0;
  endtask

  task automatic disp(input logic [5:0] o, input logic [31:0] vj, input logic rj, input logic [3:0] qj,
                      input logic [31:0] vk, input logic rk, input logic [3:0] qk,
                      input logic [31:0] im, input logic [3:0] rb);
    disp_valid = 1; disp_opt = o; disp_vj = vj; disp_rj = rj; disp_qj = qj;
    disp_vk = vk; disp_rk = rk; disp_qk = qk; disp_imm = im; disp_rob = rb;
  endtask

  task automatic step();
    model_step();
    @(posedge clk_in);
    #1;
    chk("rs_ok", rs_ok, m_ok);
    chk("opt", opt, m_opt);
    chk("rs1", rs1, m_rs1);
    chk("rs2", rs2, m_rs2);
    chk("imm", imm, m_imm);
    chk("en", en, m_en);
    chk("rs_full", rs_full, m_full());
    idle();
  endtask

  task automatic do_clear();
    clear = 1;
    step();
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{ADD, 5, 1, 0, 7, 1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 5, 7};
    vecs[1] = '{ADD, 0, 0, 6, 9, 1, 0, 1, 1, 6, 32'h55, 0, 0, 0, 1, 32'h55, 9};
    vecs[2] = '{ADD, 3, 1, 0, 0, 0, 4, 2, 0, 0, 0, 1, 4, 32'hABCD, 1, 3, 32'hABCD};
    vecs[3] = '{ADD, 0, 0, 6, 1, 1, 0, 4, 1, 5, 32'h99, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{ADD, 0, 0, 1, 0, 0, 2, 5, 1, 1, 32'h111, 1, 2, 32'h222, 1, 32'h111, 32'h222};
    vecs[5] = '{ADD, 32'h1234, 1, 7, 8, 1, 0, 6, 1, 7, 32'hDEAD, 0, 0, 0, 1, 32'h1234, 8};

    idle();
    disp_opt = 0; disp_vj = 0; disp_rj = 0; disp_qj = 0; disp_vk = 0; disp_rk = 0;
    disp_qk = 0; disp_imm = 0; disp_rob = 0;
    CDB_1_en = 0; CDB_1_val = 0; CDB_2_en = 0; CDB_2_val = 0;
    rst_in = 0;
    m_reset();
    #12;
    chk("reset_rs_ok", rs_ok, 0);
    chk("reset_opt", opt, 0);
    chk("reset_rs1", rs1, 0);
    chk("reset_en", en, 0);
    chk("reset_full", rs_full, 0);
    @(posedge clk_in); #1;
    rst_in = 1;

    for (int t = 0; t < 6; t++) begin
      do_clear();
      disp(vecs[t].op, vecs[t].vj, vecs[t].rj, vecs[t].qj, vecs[t].vk, vecs[t].rk, vecs[t].qk,
           32'h10 + t, vecs[t].rob);
      CDB_1_ok = vecs[t].c1_ok; CDB_1_en = vecs[t].c1_en; CDB_1_val = vecs[t].c1_val;
      CDB_2_ok = vecs[t].c2_ok; CDB_2_en = vecs[t].c2_en; CDB_2_val = vecs[t].c2_val;
      step();
      step();
      chk($sformatf("vec%0d_ok", t), rs_ok, vecs[t].exp_ok);
      if (vecs[t].exp_ok) begin
        chk($sformatf("vec%0d_rs1", t), rs1, vecs[t].exp_rs1);
        chk($sformatf("vec%0d_rs2", t), rs2, vecs[t].exp_rs2);
        chk($sformatf("vec%0d_en", t), en, vecs[t].rob);
      end
    end

    // ADDI woken by CDB_2 two cycles after dispatch.
    do_clear();
    disp(ADDI, 0, 0, 2, 0, 1, 0, 4, 9);
    step();
    step();
    chk("addi_wait", rs_ok, 0);
    CDB_2_ok = 1; CDB_2_en = 2; CDB_2_val = 10;
    step();
    chk("addi_not_yet", rs_ok, 0);
    step();
    chk("addi_ok", rs_ok, 1);
    chk("addi_rs1", rs1, 10);
    chk("addi_imm", imm, 4);
    chk("addi_en", en, 9);

    // Fill all entries, drop a ninth dispatch, then free one via wakeup+issue.
    do_clear();
    for (int i = 0; i < N; i++) begin
      disp(ADD, i, 0, 4'(i + 1), 0, 1, 0, 0, 4'(i));
      step();
    end
    chk("fill_full", rs_full, 1);
    disp(ADD, 32'hF, 1, 0, 32'hF, 1, 0, 0, 15);
    step();
    step();
    chk("ninth_dropped", rs_ok, 0);
    CDB_1_ok = 1; CDB_1_en = 1; CDB_1_val = 32'h11;
    step();
    chk("still_full", rs_full, 1);
    step();
    chk("fill_issue_ok", rs_ok, 1);
    chk("fill_issue_en", en, 0);
    chk("fill_issue_rs1", rs1, 32'h11);
    chk("fill_not_full", rs_full, 0);

    // Three entries woken together issue in index order.
    do_clear();
    for (int i = 0; i < 3; i++) begin
      disp(ADD, 100 + i, 1, 0, 0, 0, 5, 0, 4'(10 + i));
      step();
    end
    CDB_2_ok = 1; CDB_2_en = 5; CDB_2_val = 32'h77;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("order%0d_ok", i), rs_ok, 1);
      chk($sformatf("order%0d_en", i), en, 10 + i);
      chk($sformatf("order%0d_rs2", i), rs2, 32'h77);
    end
    step();
    chk("order_done", rs_ok, 0);

    // Stall with a ready entry, then clear it away.
    do_clear();
    disp(ADD, 32'h44, 1, 0, 1, 1, 0, 0, 4);
    rdy_in = 1;
    step();
    rdy_in = 0;
    step();
    chk("stall1", rs_ok, 0);
    rdy_in = 0;
    step();
    chk("stall2", rs_ok, 0);
    clear = 1;
    step();
    chk("clear_ok", rs_ok, 0);
    chk("clear_full", rs_full, 0);
    step();
    chk("clear_no_issue", rs_ok, 0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 39) == 0);
      disp_valid = $urandom_range(0, 1);
      disp_opt = 6'($urandom_range(0, 63));
      disp_vj = $urandom; disp_vk = $urandom; disp_imm = $urandom;
      disp_rj = $urandom_range(0, 1); disp_rk = $urandom_range(0, 1);
      disp_qj = 4'($urandom_range(0, 7)); disp_qk = 4'($urandom_range(0, 7));
      disp_rob = 4'($urandom_range(0, 15));
      CDB_1_ok = $urandom_range(0, 1); CDB_1_en = 4'($urandom_range(0, 7)); CDB_1_val = $urandom;
      CDB_2_ok = $urandom_range(0, 1); CDB_2_en = 4'($urandom_range(0, 7)); CDB_2_val = $urandom;
      if (CDB_1_ok && CDB_2_ok && CDB_1_en == CDB_2_en) CDB_2_en = CDB_2_en ^ 4'h8;
      step();
    end

    // Asynchronous reset in the middle of a cycle with entries pending.
    do_clear();
    for (int i = 0; i < 3; i++) begin
      disp(ADD, 1, 0, 3, 1, 1, 0, 0, 4'(i));
      step();
    end
    #2 rst_in = 0;
    #1;
    chk("arst_ok", rs_ok, 0);
    chk("arst_full", rs_full, 0);
    chk("arst_rs1", rs1, 0);
    m_reset();
    @(posedge clk_in); #1;
    rst_in = 1;
    CDB_1_ok = 1; CDB_1_en = 3; CDB_1_val = 5;
    step();
    step();
    chk("arst_no_issue", rs_ok, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
